// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Brief    : Shared game-status codes, colour masks and VGA timing helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam logic [1:0] GS_PLAY  = 2'b00;
    localparam logic [1:0] GS_PAUSE = 2'b01;
    localparam logic [1:0] GS_OVER  = 2'b10;
    localparam logic [1:0] GS_IDLE  = 2'b11;

    // One bit per channel, ordered {r, g, b}
    localparam logic [2:0] c_rgb_none  = 3'b000;
    localparam logic [2:0] c_rgb_wall  = 3'b100;
    localparam logic [2:0] c_rgb_apple = 3'b110;
    localparam logic [2:0] c_rgb_snake = 3'b011;

    function automatic int unsigned total4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
        return a + b + c + d;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_core
//  Brief    : Pixel-enable divider, h/v counters and sync/active/frame decode.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_CNT_W  = cnt_width(total4(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int V_CNT_W  = cnt_width(total4(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_ce,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               active,
    output logic               hs_on,
    output logic               vs_on,
    output logic               frame_tick,
    output logic               frame_start
);

    localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int VS_BEG  = V_ACTIVE + V_FP;

    generate
        if (CLK_DIV <= 1) begin : g_div_bypass
            assign pix_ce = 1'b1;
        end else begin : g_div
            localparam int DW = cnt_width(CLK_DIV);
            logic [DW-1:0] r_div_cnt;
            logic          r_pix_ce;

            // Strobe is registered one count early so it is high during the CLK_DIV-th clk
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_div_cnt <= '0;
                    r_pix_ce  <= 1'b0;
                end else begin
                    r_div_cnt <= (r_div_cnt == DW'(CLK_DIV - 1)) ? '0 : r_div_cnt + DW'(1);
                    r_pix_ce  <= (r_div_cnt == DW'(CLK_DIV - 2));
                end
            end
            assign pix_ce = r_pix_ce;
        end
    endgenerate

    logic [H_CNT_W-1:0] r_h;
    logic [V_CNT_W-1:0] r_v;
    logic               r_frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
        end else if (pix_ce) begin
            r_frame_start <= (r_h == '0) && (r_v == '0);
            if (r_h == H_CNT_W'(H_TOTAL - 1)) begin
                r_h <= '0;
                r_v <= (r_v == V_CNT_W'(V_TOTAL - 1)) ? '0 : r_v + V_CNT_W'(1);
            end else begin
                r_h <= r_h + H_CNT_W'(1);
            end
        end
    end

    assign h_cnt       = r_h;
    assign v_cnt       = r_v;
    assign active      = (r_h < H_CNT_W'(H_ACTIVE)) && (r_v < V_CNT_W'(V_ACTIVE));
    assign hs_on       = (r_h >= H_CNT_W'(HS_BEG)) && (r_h < H_CNT_W'(HS_BEG + H_SYNC));
    assign vs_on       = (r_v >= V_CNT_W'(VS_BEG)) && (r_v < V_CNT_W'(VS_BEG + V_SYNC));
    assign frame_tick  = pix_ce && (r_h == '0) && (r_v == '0);
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/vga_grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_grid_renderer
//  Brief    : Snake-game VGA renderer: timing core, cell pipeline, compositor.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_grid_renderer
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int CELL_SHIFT = 4,
    parameter int CELL_W     = 6,
    parameter int WALL_CELLS = 1,
    parameter int BLINK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         game_status,
    input  logic [CELL_W-1:0]  apple_cx,
    input  logic [CELL_W-1:0]  apple_cy,
    input  logic               snake_hit,
    output logic               pix_ce,
    output logic [CELL_W-1:0]  cell_x,
    output logic [CELL_W-1:0]  cell_y,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs
);

    localparam int H_CNT_W = cnt_width(total4(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int V_CNT_W = cnt_width(total4(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int H_CELLS = H_ACTIVE >> CELL_SHIFT;
    localparam int V_CELLS = V_ACTIVE >> CELL_SHIFT;
    localparam int FC_W    = BLINK_LOG2 + 1;
    localparam logic [COLOR_W-1:0] c_full = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] c_half = c_full >> 1;

    logic [H_CNT_W-1:0] w_h;
    logic [V_CNT_W-1:0] w_v;
    logic               w_active, w_hs_on, w_vs_on, w_frame_tick;

    vga_timing_core #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_CNT_W (H_CNT_W),  .V_CNT_W(V_CNT_W)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .h_cnt      (w_h),
        .v_cnt      (w_v),
        .active     (w_active),
        .hs_on      (w_hs_on),
        .vs_on      (w_vs_on),
        .frame_tick (w_frame_tick),
        .frame_start(frame_start)
    );

    // S1: cell coordinates and delayed sync/active flags
    logic [CELL_W-1:0] r_cell_x, r_cell_y;
    logic              r_active, r_hs_on, r_vs_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_active <= 1'b0;
            r_hs_on  <= 1'b0;
            r_vs_on  <= 1'b0;
        end else if (pix_ce) begin
            r_cell_x <= w_active ? CELL_W'(w_h >> CELL_SHIFT) : '0;
            r_cell_y <= w_active ? CELL_W'(w_v >> CELL_SHIFT) : '0;
            r_active <= w_active;
            r_hs_on  <= w_hs_on;
            r_vs_on  <= w_vs_on;
        end
    end

    assign cell_x = r_cell_x;
    assign cell_y = r_cell_y;

    // Status and blink counter only move on the first pixel, so a frame is never torn
    logic [1:0]      r_status;
    logic [FC_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status    <= GS_IDLE;
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_status <= game_status;
            if ((game_status == GS_OVER) && (r_status != GS_OVER))
                r_frame_cnt <= '0;
            else
                r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
    end

    logic w_wall, w_apple, w_blink, w_dim;
    logic [2:0]         w_mask;
    logic [COLOR_W-1:0] w_level;

    assign w_wall  = (r_cell_x <  CELL_W'(WALL_CELLS))
                  || (r_cell_x >= CELL_W'(H_CELLS - WALL_CELLS))
                  || (r_cell_y <  CELL_W'(WALL_CELLS))
                  || (r_cell_y >= CELL_W'(V_CELLS - WALL_CELLS));
    assign w_apple = (r_cell_x == apple_cx) && (r_cell_y == apple_cy);
    assign w_blink = r_frame_cnt[BLINK_LOG2];

    always_comb begin
        w_mask = c_rgb_none;
        w_dim  = 1'b0;
        if (r_active) begin
            if (w_wall) begin
                w_mask = c_rgb_wall;
            end else begin
                case (r_status)
                    GS_PLAY, GS_PAUSE: begin
                        if (w_apple)
                            w_mask = c_rgb_apple;
                        else if (snake_hit)
                            w_mask = c_rgb_snake;
                        w_dim = (r_status == GS_PAUSE);
                    end
                    GS_OVER:  w_mask = w_blink ? c_rgb_wall : c_rgb_none;
                    default:  w_mask = c_rgb_none;
                endcase
            end
        end
    end

    assign w_level = w_dim ? c_half : c_full;

    // S2: pins, with sync and colour leaving together
    logic [COLOR_W-1:0] r_r, r_g, r_b;
    logic               r_hs, r_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
        end else if (pix_ce) begin
            r_r  <= w_mask[2] ? w_level : '0;
            r_g  <= w_mask[1] ? w_level : '0;
            r_b  <= w_mask[0] ? w_level : '0;
            r_hs <= r_hs_on ? HS_POL : ~HS_POL;
            r_vs <= r_vs_on ? VS_POL : ~VS_POL;
        end
    end

    assign vga_r  = r_r;
    assign vga_g  = r_g;
    assign vga_b  = r_b;
    assign vga_hs = r_hs;
    assign vga_vs = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_grid_renderer
//  Brief    : Directed bench on a shrunken 32x24 display with 4x4-pixel cells.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_grid_renderer;

    localparam int CLK_DIV = 4;
    localparam int HT      = 40;          // 32 + 2 + 4 + 2
    localparam int VT      = 28;          // 24 + 1 + 2 + 1
    localparam int NPIX    = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] game_status = 2'b11;
    logic [3:0] apple_cx = 4'd3, apple_cy = 4'd2;
    logic       snake_hit;
    logic       pix_ce, frame_start, vga_hs, vga_vs;
    logic [3:0] cell_x, cell_y, vga_r, vga_g, vga_b;
    int         smode = 0;

    vga_grid_renderer #(
        .CLK_DIV(CLK_DIV),
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(24), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(4),
        .CELL_SHIFT(2), .CELL_W(4), .WALL_CELLS(1), .BLINK_LOG2(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_status(game_status),
        .apple_cx(apple_cx), .apple_cy(apple_cy), .snake_hit(snake_hit),
        .pix_ce(pix_ce), .cell_x(cell_x), .cell_y(cell_y), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    always #5 clk = ~clk;

    // Snake store model: 0 none, 1 every cell, 2 only cell (5,3)
    always_comb snake_hit = (smode == 1) || ((smode == 2) && (cell_x == 4'd5) && (cell_y == 4'd3));

    int n_pass = 0, n_total = 0;
    int pos = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic abort(input string why);
        n_total++;
        $display("FAIL %s: timeout", why);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "bench aborted");
    endtask

    // Advance past the next pix_ce edge; called and returns on a negedge
    task automatic next_pix();
        int guard = 0;
        while (!pix_ce) begin
            @(negedge clk);
            guard++;
            if (guard > 4 * CLK_DIV) abort("pix_ce");
        end
        @(negedge clk);
    endtask

    task automatic wait_frame();
        int g = 0;
        do begin
            next_pix();
            g++;
        end while (!frame_start && g <= NPIX + 2);
        if (!frame_start) abort("frame_start");
        pos = -1;
    endtask

    task automatic goto_pix(input int x, input int y);
        while (pos < y * HT + x) begin
            next_pix();
            pos++;
        end
    endtask

    function automatic logic [23:0] out_tuple();
        return {pix_ce, cell_x, cell_y, frame_start, vga_r, vga_g, vga_b, vga_hs, vga_vs};
    endfunction

    localparam logic [23:0] RESET_TUPLE = {1'b0, 4'd0, 4'd0, 1'b0, 12'h000, 1'b1, 1'b0};

    typedef struct {
        logic [1:0]  st;
        logic [3:0]  ax, ay;
        int          sm, px, py;
        logic [13:0] exp;   // {r,g,b,hs,vs}
    } vec_t;

    function automatic vec_t mk(input logic [1:0] st, input logic [3:0] ax, input logic [3:0] ay,
                                input int sm, input int px, input int py,
                                input logic [11:0] rgb, input logic hs, input logic vs);
        vec_t v;
        v.st = st; v.ax = ax; v.ay = ay; v.sm = sm; v.px = px; v.py = py;
        v.exp = {rgb, hs, vs};
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        #1_500_000;
        abort("watchdog");
    end

    initial begin
        int hs_n0 = 0, hs_first = -1, hs_tot = 0, vs_n = 0, vs_first = -1, fs_n = 0, fs_idx = -1;
        logic [1:0] cur_st;

        tbl[0]  = mk(2'b00, 4'd3,  4'd2,  2, 0,  0,  12'hF00, 1'b1, 1'b0);
        tbl[1]  = mk(2'b00, 4'd3,  4'd2,  2, 35, 0,  12'h000, 1'b0, 1'b0);
        tbl[2]  = mk(2'b00, 4'd3,  4'd2,  2, 12, 8,  12'hFF0, 1'b1, 1'b0);
        tbl[3]  = mk(2'b00, 4'd3,  4'd2,  2, 15, 11, 12'hFF0, 1'b1, 1'b0);
        tbl[4]  = mk(2'b00, 4'd3,  4'd2,  2, 16, 11, 12'h000, 1'b1, 1'b0);
        tbl[5]  = mk(2'b00, 4'd3,  4'd2,  2, 20, 12, 12'h0FF, 1'b1, 1'b0);
        tbl[6]  = mk(2'b00, 4'd3,  4'd2,  2, 31, 12, 12'hF00, 1'b1, 1'b0);
        tbl[7]  = mk(2'b00, 4'd3,  4'd2,  2, 10, 22, 12'hF00, 1'b1, 1'b0);
        tbl[8]  = mk(2'b00, 4'd0,  4'd2,  0, 2,  9,  12'hF00, 1'b1, 1'b0);
        tbl[9]  = mk(2'b00, 4'd15, 4'd15, 1, 12, 8,  12'h0FF, 1'b1, 1'b0);
        tbl[10] = mk(2'b00, 4'd15, 4'd15, 1, 0,  12, 12'hF00, 1'b1, 1'b0);
        tbl[11] = mk(2'b00, 4'd15, 4'd15, 1, 5,  25, 12'h000, 1'b1, 1'b1);
        tbl[12] = mk(2'b01, 4'd3,  4'd2,  2, 13, 9,  12'h770, 1'b1, 1'b0);
        tbl[13] = mk(2'b01, 4'd3,  4'd2,  2, 21, 13, 12'h077, 1'b1, 1'b0);
        tbl[14] = mk(2'b01, 4'd3,  4'd2,  2, 0,  10, 12'hF00, 1'b1, 1'b0);
        tbl[15] = mk(2'b11, 4'd3,  4'd2,  1, 13, 9,  12'h000, 1'b1, 1'b0);
        tbl[16] = mk(2'b11, 4'd3,  4'd2,  1, 0,  0,  12'hF00, 1'b1, 1'b0);

        // Reset state and divider start-up
        repeat (10) @(negedge clk);
        check("reset_outputs", out_tuple(), RESET_TUPLE);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("pix_ce_after_edge%0d", k), pix_ce, (k == 3));
        end
        check("first_frame_start", frame_start, 1'b1);
        pos = -1;

        // One full frame of sync/frame_start timing
        for (int i = 0; i < NPIX; i++) begin
            next_pix();
            if (vga_hs == 1'b0) begin
                hs_tot++;
                if (i < HT) begin
                    hs_n0++;
                    if (hs_first < 0) hs_first = i;
                end
            end
            if (vga_vs == 1'b1) begin
                vs_n++;
                if (vs_first < 0) vs_first = i;
            end
            if (frame_start) begin
                fs_n++;
                fs_idx = i;
            end
        end
        pos = -1;
        check("hs_first_pixel", hs_first, 34);
        check("hs_width_line0", hs_n0, 4);
        check("hs_total_frame", hs_tot, 4 * VT);
        check("vs_first_pixel", vs_first, 25 * HT);
        check("vs_width", vs_n, 2 * HT);
        check("frame_start_count", fs_n, 1);
        check("frame_start_period", fs_idx, NPIX - 1);

        // Composite table
        cur_st = 2'b11;
        for (int i = 0; i < 17; i++) begin
            apple_cx = tbl[i].ax;
            apple_cy = tbl[i].ay;
            smode    = tbl[i].sm;
            if (tbl[i].st != cur_st || (tbl[i].py * HT + tbl[i].px) <= pos) begin
                game_status = tbl[i].st;
                wait_frame();
                cur_st = tbl[i].st;
            end
            goto_pix(tbl[i].px, tbl[i].py);
            check($sformatf("vec%0d_rgbhv", i), {vga_r, vga_g, vga_b, vga_hs, vga_vs}, tbl[i].exp);
        end

        // Mid-frame switch to game over, then blink sequence
        apple_cx = 4'd3; apple_cy = 4'd2; smode = 0;
        game_status = 2'b00;
        wait_frame();
        goto_pix(0, 2);
        game_status = 2'b10;
        goto_pix(13, 9);
        check("no_tear_apple", {vga_r, vga_g, vga_b}, 12'hFF0);
        for (int f = 0; f < 5; f++) begin
            wait_frame();
            goto_pix(13, 9);
            check($sformatf("over_frame%0d_interior", f), {vga_r, vga_g, vga_b},
                  (f == 2 || f == 3) ? 12'hF00 : 12'h000);
        end
        goto_pix(3, 10);
        check("over_wall", {vga_r, vga_g, vga_b}, 12'hF00);

        // Asynchronous reset mid-frame, then clean restart
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_tuple(), RESET_TUPLE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) check("restart_pix_ce", pix_ce, 1'b1);
        end
        check("restart_frame_start", frame_start, 1'b1);
        pos = -1;
        goto_pix(0, 0);
        check("restart_wall", {vga_r, vga_g, vga_b}, 12'hF00);
        goto_pix(13, 9);
        check("restart_blink_cleared", {vga_r, vga_g, vga_b}, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
